// File: rtl/acc_cpu_pkg.sv
// Shared types for the 11-bit accumulator CPU: opcodes, mux/ALU encodings,
// control FSM states and the decoder's result record.
package acc_cpu_pkg;

  localparam int OPC_W   = 5;
  localparam int DATA_W  = 11;
  localparam int INSTR_W = OPC_W + DATA_W;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT  = 5'h00, OP_STO  = 5'h01, OP_LD   = 5'h02, OP_LDI  = 5'h03,
    OP_ADD  = 5'h04, OP_ADDI = 5'h05, OP_SUB  = 5'h06, OP_SUBI = 5'h07,
    OP_AND  = 5'h08, OP_OR   = 5'h09, OP_JMP  = 5'h0A, OP_BEQ  = 5'h0B,
    OP_BNE  = 5'h0C, OP_BLT  = 5'h0D, OP_NOP  = 5'h0E
  } opcode_e;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_EXT = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_HALT, CLS_MEM, CLS_STO, CLS_LDI, CLS_IMM, CLS_BRANCH, CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {BR_ALWAYS, BR_ZERO, BR_NZERO, BR_NEG} br_sel_e;

  typedef struct packed {
    op_class_e cls;
    alu_op_e   alu_op;
    br_sel_e   br_sel;
    logic      ld_mem;   // MEM-class op that loads memory straight into acc
  } dec_t;

endpackage

// File: rtl/acc_instr_decoder.sv
// Combinational opcode classifier: instruction class, ALU operation and
// branch condition select for the control FSM.
module acc_instr_decoder
  import acc_cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);

  always_comb begin
    dec = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, br_sel: BR_ALWAYS, ld_mem: 1'b0};
    case (opcode)
      OP_HLT:  dec.cls = CLS_HALT;
      OP_STO:  dec.cls = CLS_STO;
      OP_LD:   begin dec.cls = CLS_MEM; dec.ld_mem = 1'b1; end
      OP_LDI:  dec.cls = CLS_LDI;
      OP_ADD:  dec.cls = CLS_MEM;
      OP_ADDI: dec.cls = CLS_IMM;
      OP_SUB:  begin dec.cls = CLS_MEM; dec.alu_op = ALU_SUB; end
      OP_SUBI: begin dec.cls = CLS_IMM; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.cls = CLS_MEM; dec.alu_op = ALU_AND; end
      OP_OR:   begin dec.cls = CLS_MEM; dec.alu_op = ALU_OR;  end
      OP_JMP:  dec.cls = CLS_BRANCH;
      OP_BEQ:  begin dec.cls = CLS_BRANCH; dec.br_sel = BR_ZERO;  end
      OP_BNE:  begin dec.cls = CLS_BRANCH; dec.br_sel = BR_NZERO; end
      OP_BLT:  begin dec.cls = CLS_BRANCH; dec.br_sel = BR_NEG;   end
      OP_NOP:  dec.cls = CLS_NOP;
      default: dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/acc_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control for the accumulator datapath.
// Define ACC_CTRL_MEM_WAIT_EN to add a mem_ready handshake on MEM and STO.
module acc_control_unit #(
  parameter int OPC_W  = 5,
  parameter int DATA_W = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPC_W+DATA_W-1:0] instr_in,
  input  logic                    acc_zero,
  input  logic                    acc_neg,
`ifdef ACC_CTRL_MEM_WAIT_EN
  input  logic                    mem_ready,
`endif
  output logic                    instr_rd,
  output logic [DATA_W-1:0]       operand_out,
  output logic [1:0]              sel_A,
  output logic [1:0]              alu_op,
  output logic                    alu_src_imm,
  output logic                    acc_wr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic                    halted,
  output logic                    illegal
);
  import acc_cpu_pkg::*;

  state_e                  state, state_nx;
  logic [OPC_W+DATA_W-1:0] ir;
  logic                    illegal_q;
  logic                    br_taken;
  logic                    mem_done;
  dec_t                    dec;

  acc_instr_decoder u_dec (
    .opcode (ir[OPC_W+DATA_W-1:DATA_W]),
    .dec    (dec)
  );

  assign operand_out = ir[DATA_W-1:0];

`ifdef ACC_CTRL_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) ir <= instr_in;
      if (state == S_EXEC && dec.cls == CLS_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    case (dec.br_sel)
      BR_ZERO:  br_taken = acc_zero;
      BR_NZERO: br_taken = !acc_zero;
      BR_NEG:   br_taken = acc_neg;
      default:  br_taken = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if (dec.cls == CLS_HALT)     state_nx = S_HALT;
        else if (dec.cls == CLS_MEM) state_nx = S_MEM;
        else                         state_nx = S_EXEC;
      end
      S_EXEC:   if (dec.cls != CLS_STO || mem_done) state_nx = S_FETCH;
      S_MEM:    if (mem_done) state_nx = S_WB;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst_n is low so an aborted instruction
  // cannot write the accumulator, memory or PC in the reset cycle.
  always_comb begin
    instr_rd    = 1'b0;
    sel_A       = SEL_ALU;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    acc_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    illegal     = rst_n & illegal_q;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          instr_rd = 1'b1;
          pc_inc   = 1'b1;
        end
        S_EXEC: begin
          case (dec.cls)
            CLS_STO:    mem_wr = 1'b1;
            CLS_LDI:    begin sel_A = SEL_EXT; acc_wr = 1'b1; end
            CLS_IMM:    begin
              alu_src_imm = 1'b1;
              sel_A       = SEL_ALU;
              alu_op      = dec.alu_op;
              acc_wr      = 1'b1;
            end
            CLS_BRANCH: pc_load = br_taken;
            default:    ;
          endcase
        end
        S_MEM:   mem_rd = 1'b1;
        S_WB: begin
          sel_A  = dec.ld_mem ? SEL_MEM : SEL_ALU;
          alu_op = dec.alu_op;
          acc_wr = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed scoreboard bench for acc_control_unit: each instruction pushes its
// expected per-cycle control vectors, which are popped and checked every cycle.
module tb_acc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        acc_zero, acc_neg;
  logic        instr_rd, alu_src_imm, acc_wr, mem_rd, mem_wr, pc_inc, pc_load, halted, illegal;
  logic [10:0] operand_out;
  logic [1:0]  sel_A, alu_op;
`ifdef ACC_CTRL_MEM_WAIT_EN
  logic        mem_ready = 1'b1;
`endif

  acc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .acc_zero(acc_zero), .acc_neg(acc_neg),
`ifdef ACC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .instr_rd(instr_rd), .operand_out(operand_out), .sel_A(sel_A), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .acc_wr(acc_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        instr_rd;
    logic [1:0]  sel_A;
    logic [1:0]  alu_op;
    logic        alu_src_imm, acc_wr, mem_rd, mem_wr, pc_inc, pc_load, halted, illegal;
    logic [10:0] operand;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    tests = 0, fails = 0;
  logic [10:0] ir_m;   // model of the operand register
  logic        ill_m;  // model of the sticky illegal flag

  function automatic obs_t cur();
    obs_t o;
    o = '{instr_rd, sel_A, alu_op, alu_src_imm, acc_wr, mem_rd, mem_wr,
          pc_inc, pc_load, halted, illegal, operand_out};
    return o;
  endfunction

  function automatic obs_t base();
    obs_t e = '0;
    e.illegal = ill_m;
    e.operand = ir_m;
    return e;
  endfunction

  task automatic check(input obs_t e, input string tag);
    obs_t o = cur();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input obs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Spec-derived expected control sequence for one instruction.
  task automatic push_instr(input logic [15:0] ins, input logic z, input logic n);
    logic [4:0] op = ins[15:11];
    obs_t e;
    e = base(); e.instr_rd = 1'b1; e.pc_inc = 1'b1; push(e, "fetch");
    ir_m = ins[10:0];
    e = base(); push(e, "decode");
    if (op == 5'h00) begin
      for (int i = 0; i < 20; i++) begin
        e = base(); e.halted = 1'b1; push(e, "halt");
      end
    end else if (op == 5'h02 || op == 5'h04 || op == 5'h06 || op == 5'h08 || op == 5'h09) begin
      e = base(); e.mem_rd = 1'b1; push(e, "mem");
      e = base(); e.acc_wr = 1'b1;
      e.sel_A  = (op == 5'h02) ? 2'b10 : 2'b00;
      e.alu_op = (op == 5'h06) ? 2'd1 : (op == 5'h08) ? 2'd2 : (op == 5'h09) ? 2'd3 : 2'd0;
      push(e, "wb");
    end else begin
      e = base();
      case (op)
        5'h01: e.mem_wr = 1'b1;
        5'h03: begin e.sel_A = 2'b01; e.acc_wr = 1'b1; end
        5'h05: begin e.alu_src_imm = 1'b1; e.acc_wr = 1'b1; e.alu_op = 2'd0; end
        5'h07: begin e.alu_src_imm = 1'b1; e.acc_wr = 1'b1; e.alu_op = 2'd1; end
        5'h0A: e.pc_load = 1'b1;
        5'h0B: e.pc_load = z;
        5'h0C: e.pc_load = !z;
        5'h0D: e.pc_load = n;
        default: ;
      endcase
      push(e, "exec");
      if (op >= 5'h0F) ill_m = 1'b1;
    end
  endtask

  task automatic pop_check();
    obs_t  e   = exp_q.pop_front();
    string tag = tag_q.pop_front();
    check(e, tag);
  endtask

  // Called at negedge+1; leaves the bench at negedge+1 of the next FETCH.
  task automatic run(input logic [15:0] ins, input logic z, input logic n);
    instr_in = ins; acc_zero = z; acc_neg = n;
    #1;
    push_instr(ins, z, n);
    while (exp_q.size() > 0) begin
      pop_check();
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset(input bit chk_now);
    obs_t e;
    rst_n = 1'b0;
    #1;
    if (chk_now) begin
      e = '0; e.operand = ir_m; check(e, "rst_cycle");
    end
    @(posedge clk); #1;
    e = '0; check(e, "rst_state");
    rst_n = 1'b1;
    ir_m = '0; ill_m = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_in = '0; acc_zero = 1'b0; acc_neg = 1'b0;
    ir_m = '0; ill_m = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    run(16'h1871, 1'b0, 1'b0);  // LDI 0x071
    run(16'h1064, 1'b0, 1'b0);  // LD 0x064
    run(16'h2005, 1'b0, 1'b0);  // ADD 0x005
    run(16'h3802, 1'b0, 1'b0);  // SUBI 0x002
    run(16'h2801, 1'b0, 1'b0);  // ADDI
    run(16'h4003, 1'b0, 1'b0);  // AND
    run(16'h4807, 1'b0, 1'b0);  // OR
    run(16'h0855, 1'b0, 1'b0);  // STO
    run(16'h5123, 1'b0, 1'b0);  // JMP
    run(16'h5810, 1'b1, 1'b0);  // BEQ taken
    run(16'h5810, 1'b0, 1'b1);  // BEQ not taken
    run(16'h6010, 1'b0, 1'b0);  // BNE taken
    run(16'h6010, 1'b1, 1'b0);  // BNE not taken
    run(16'h6810, 1'b0, 1'b1);  // BLT taken
    run(16'h6810, 1'b1, 1'b0);  // BLT not taken
    run(16'h7000, 1'b1, 1'b1);  // NOP
    run(16'hFFFF, 1'b1, 1'b1);  // opcode 0x1F -> illegal
    run(16'h7800, 1'b0, 1'b0);  // opcode 0x0F, also illegal
    run(16'h7000, 1'b0, 1'b0);  // illegal stays set

    // Reset asserted during WB of ADD: no acc_wr, restart at FETCH.
    instr_in = 16'h2005; #1;
    push_instr(16'h2005, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pop_check();
      @(negedge clk); #1;
    end
    void'(exp_q.pop_front());
    void'(tag_q.pop_front());
    do_reset(1'b1);
    run(16'h1871, 1'b0, 1'b0);

`ifdef ACC_CTRL_MEM_WAIT_EN
    begin
      obs_t e;
      instr_in = 16'h1064; mem_ready = 1'b0; #1;
      e = base(); e.instr_rd = 1'b1; e.pc_inc = 1'b1; check(e, "wait_fetch");
      ir_m = 11'h064;
      @(negedge clk); #1; e = base(); check(e, "wait_decode");
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        if (i == 3) mem_ready = 1'b1;
        e = base(); e.mem_rd = 1'b1; check(e, "wait_mem");
      end
      @(negedge clk); #1;
      mem_ready = 1'b1;
      e = base(); e.acc_wr = 1'b1; e.sel_A = 2'b10; check(e, "wait_wb");
      @(negedge clk); #1;
    end
`endif

    run(16'h0000, 1'b0, 1'b0);  // HLT: 20 halted cycles
    do_reset(1'b1);
    run(16'h7000, 1'b0, 1'b0);  // clean FETCH with halted/illegal cleared

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
